ysyx_22041207_mem_responder: RTL

Memory-side responder for the core's load/store request/response handshake. It accepts one write or one read request at a time from the memory stage, services it against an internal word-addressed SRAM after a configurable latency, and returns a write acknowledge or right-aligned read data. It sits between the memory stage's bus initiator and backing storage, and replaces the simulation-only memory model in standalone RTL tests.

---
 rtl/ysyx_22041207_mem_responder_pkg.sv | 39 +++
 rtl/ysyx_22041207_mem_responder_if.sv | 39 +++
 rtl/ysyx_22041207_sram_bytewe.sv | 29 ++
 rtl/ysyx_22041207_mem_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_mem_responder_pkg.sv
// rtl/ysyx_22041207_mem_responder_pkg.sv - shared widths, FSM states and address helpers
// Holds the bus width constants, the responder state encoding and two small
// decode helpers used when a request is accepted.
package ysyx_22041207_mem_responder_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_WR_WAIT = 3'd1;
    localparam state_t S_WR_RESP = 3'd2;
    localparam state_t S_RD_WAIT = 3'd3;
    localparam state_t S_RD_RESP = 3'd4;

    // The offset compare is done after the subtraction so a window that ends
    // exactly at the top of the address space does not overflow.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W-1:0] span);
        logic [ADDR_W-1:0] off;
        off = addr - base;
        return (addr >= base) && (off < span);
    endfunction

    // A read is malformed when the size is not a power of two up to 8 or
    // when it would run past the end of the 8-byte word.
    function automatic logic rd_size_bad(input logic [2:0] lane,
                                         input logic [7:0] size);
        logic [8:0] end_byte;
        logic       size_ok;
        end_byte = {6'd0, lane} + {1'b0, size};
        size_ok  = (size == 8'd1) || (size == 8'd2) || (size == 8'd4) || (size == 8'd8);
        return !size_ok || (end_byte > 9'd8);
    endfunction

endpackage

// File: rtl/ysyx_22041207_mem_responder_if.sv
// rtl/ysyx_22041207_mem_responder_if.sv - load/store request/response bundle
// master: memory-stage initiator; slave: memory responder.
// Write channel: w_valid_i/w_ready_o/w_addr_i/w_data_i/w_mask_i, response w_valid_o/w_ready_i.
// Read channel: rx_r_valid_i/rx_r_ready_o/rx_r_addr_i/rx_r_size_i,
// response rx_data_read_o/rx_data_valid/rx_data_ready. access_fault is a one-cycle pulse.
interface ysyx_22041207_mem_responder_if;
    import ysyx_22041207_mem_responder_pkg::*;

    logic              w_valid_i;
    logic              w_ready_o;
    logic [ADDR_W-1:0] w_addr_i;
    logic [DATA_W-1:0] w_data_i;
    logic [MASK_W-1:0] w_mask_i;
    logic              w_valid_o;
    logic              w_ready_i;
    logic              rx_r_valid_i;
    logic              rx_r_ready_o;
    logic [ADDR_W-1:0] rx_r_addr_i;
    logic [7:0]        rx_r_size_i;
    logic [DATA_W-1:0] rx_data_read_o;
    logic              rx_data_valid;
    logic              rx_data_ready;
    logic              access_fault;

    modport slave (
        input  w_valid_i, w_addr_i, w_data_i, w_mask_i, w_ready_i,
        input  rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
        output w_ready_o, w_valid_o, rx_r_ready_o, rx_data_read_o, rx_data_valid,
        output access_fault
    );

    modport master (
        output w_valid_i, w_addr_i, w_data_i, w_mask_i, w_ready_i,
        output rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
        input  w_ready_o, w_valid_o, rx_r_ready_o, rx_data_read_o, rx_data_valid,
        input  access_fault
    );

endinterface

// File: rtl/ysyx_22041207_sram_bytewe.sv
// rtl/ysyx_22041207_sram_bytewe.sv - single-port synchronous SRAM with byte write enables
// Ports: clk; addr_i word index; we_i/be_i/wdata_i byte-masked write;
// rdata_o registered read of addr_i (old data on a same-cycle write). Contents are not reset.
module ysyx_22041207_sram_bytewe #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr_i,
    input  logic             we_i,
    input  logic [7:0]       be_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 8; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/ysyx_22041207_mem_responder.sv
// rtl/ysyx_22041207_mem_responder.sv - memory-side responder for load/store requests
// Ports: clk, rst (async, active high), bus (slave modport of the request/response bundle).
// Accepts one write or read at a time (write wins a tie), waits LATENCY cycles,
// then returns a write ack or right-aligned read data from an internal SRAM.
module ysyx_22041207_mem_responder
    import ysyx_22041207_mem_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned       DEPTH_WORDS = 4096,
    parameter int unsigned       LATENCY     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22041207_mem_responder_if.slave bus
);

    localparam int unsigned       IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(DEPTH_WORDS) << 3;
    // The SRAM read needs one cycle, so reads always wait at least one cycle.
    localparam int unsigned       RD_LAT  = (LATENCY == 0) ? 1 : LATENCY;
    localparam logic [31:0]       WR_LAST = (LATENCY == 0) ? 32'd0 : 32'(LATENCY - 1);
    localparam logic [31:0]       RD_LAST = 32'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              ok_q, ok_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [ADDR_W-1:0] sram_addr;
    logic [IDX_W-1:0]  sram_idx;
    logic              sram_we;
    logic [DATA_W-1:0] sram_rdata;
    logic              w_in_range;
    logic              r_in_range;

    assign w_in_range = addr_in_range(bus.w_addr_i, BASE_ADDR, SPAN);
    assign r_in_range = addr_in_range(bus.rx_r_addr_i, BASE_ADDR, SPAN);

    // While idle the SRAM is pointed at the incoming request so a read is
    // already in flight on the accept edge; afterwards it holds the latched address.
    always_comb begin
        sram_addr = addr_q;
        if (state_q == S_IDLE) begin
            sram_addr = bus.w_valid_i ? bus.w_addr_i : bus.rx_r_addr_i;
        end
    end

    assign sram_idx = IDX_W'((sram_addr - BASE_ADDR) >> 3);
    // Rewriting the same bytes every WR_RESP cycle is idempotent, so no
    // separate "already committed" flag is needed.
    assign sram_we  = (state_q == S_WR_RESP) && ok_q;

    ysyx_22041207_sram_bytewe #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk     (clk),
        .addr_i  (sram_idx),
        .we_i    (sram_we),
        .be_i    (mask_q),
        .wdata_i (data_q),
        .rdata_o (sram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        ok_d      = ok_q;
        fault_d   = 1'b0;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.w_valid_i) begin
                    addr_d  = bus.w_addr_i;
                    data_d  = bus.w_data_i;
                    mask_d  = bus.w_mask_i;
                    ok_d    = w_in_range;
                    fault_d = !w_in_range;
                    cnt_d   = 32'd0;
                    state_d = (LATENCY == 0) ? S_WR_RESP : S_WR_WAIT;
                end else if (bus.rx_r_valid_i) begin
                    addr_d  = bus.rx_r_addr_i;
                    ok_d    = r_in_range;
                    fault_d = !r_in_range || rd_size_bad(bus.rx_r_addr_i[2:0], bus.rx_r_size_i);
                    cnt_d   = 32'd0;
                    state_d = S_RD_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = 32'd0;
                    state_d = S_WR_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d     = 32'd0;
                    state_d   = S_RD_RESP;
                    rd_data_d = ok_q ? (sram_rdata >> {addr_q[2:0], 3'b000}) : '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WR_RESP: begin
                if (bus.w_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_RESP: begin
                if (bus.rx_data_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 32'd0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            ok_q      <= 1'b0;
            fault_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            ok_q      <= ok_d;
            fault_q   <= fault_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.w_ready_o      = (state_q == S_IDLE);
    assign bus.rx_r_ready_o   = (state_q == S_IDLE);
    assign bus.w_valid_o      = (state_q == S_WR_RESP);
    assign bus.rx_data_valid  = (state_q == S_RD_RESP);
    assign bus.rx_data_read_o = rd_data_q;
    assign bus.access_fault   = fault_q;

endmodule
